// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared definitions for the MEM-stage load/store unit: access-size
//   encodings, LSU FSM state encodings, the latched-op record and the
//   alignment test used to detect misaligned accesses.
package mem_pkg;

  localparam int XLEN_P  = 32;
  localparam int PC_P    = 32;

  // Access size as carried on EX_size; 2'b11 is treated as a word.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Operation held in the MEM stage.
  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] alu_res;
    logic [XLEN_P-1:0] store_data;
    logic [4:0]        rd;
    logic              we;
    logic [PC_P-1:0]   pc;
    logic              jlx;
    logic              store;
    logic [1:0]        size;
    logic              uns;
    logic              mis;
  } op_t;

  // Half needs a[0]==0, word needs a[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic r;
    r = 1'b0;
    if (size == SZ_H)      r = a[0];
    else if (size != SZ_B) r = (a != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
//   Combinational lane logic for the load/store unit.
//   Store side: byte enables and lane-replicated write data.
//   Load side:  lane extraction from the raw word and sign/zero extension.
//   Low address bits that would make a half/word misaligned are ignored,
//   so such accesses behave as if forced to natural alignment.
// Ports
//   size        in  2   access size (SZ_B / SZ_H / SZ_W, 11 = word)
//   addr_lo     in  2   effective address bits [1:0]
//   is_unsigned in  1   zero-extend loads
//   store_data  in  32  store value (rs2)
//   rdata       in  32  raw word returned by memory
//   be          out 4   byte enables
//   wdata       out 32  write data replicated into every lane
//   ld_data     out 32  formatted load result
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be      = 4'b1111;
    wdata   = store_data;
    ld_data = rdata;
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase

    case (size)
      SZ_B: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{store_data[7:0]}};
        ld_data = is_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        be      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{store_data[15:0]}};
        ld_data = is_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        be      = 4'b1111;
        wdata   = store_data;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM pipeline stage / load-store unit between EX and the MEM->WB register.
//   Latches one EX op per unstalled edge, runs the data-memory req/ack
//   handshake for loads and stores, formats load data and presents the
//   result to WB. EX is held (mem_stall) while an access is outstanding.
// Configuration macro
//   MEM_MISALIGN_EXC_EN  defined: misaligned half/word accesses issue no
//                        request, go straight to RESP with MEM_misalign=1
//                        and MEM_we=0. Undefined: MEM_misalign is 0 and the
//                        offending address bits are ignored.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   EX_valid/alu_res/store_data/rd/we/pc/jlx/load/store/size/unsigned
//                                op from EX
//   mem_stall                    EX must hold its op
//   dmem_req/we/addr/wdata/be    data-memory request (held until ack)
//   dmem_ack/rdata               data-memory response
//   MEM_data_mem/rd/we/pc/jlx    result to WB
//   MEM_misalign                 misaligned access flag
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EX_valid,
  input  logic [XLEN-1:0]    EX_alu_res,
  input  logic [XLEN-1:0]    EX_store_data,
  input  logic [4:0]         EX_rd,
  input  logic               EX_we,
  input  logic [PC_BITS-1:0] EX_pc,
  input  logic               EX_jlx,
  input  logic               EX_load,
  input  logic               EX_store,
  input  logic [1:0]         EX_size,
  input  logic               EX_unsigned,
  output logic               mem_stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [XLEN/8-1:0]  dmem_be,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [XLEN-1:0]    MEM_data_mem,
  output logic [4:0]         MEM_rd,
  output logic               MEM_we,
  output logic [PC_BITS-1:0] MEM_pc,
  output logic               MEM_jlx,
  output logic               MEM_misalign
);

  state_e           state, state_nx;
  op_t              op_r, op_nx;
  logic [XLEN-1:0]  ld_r;
  logic [3:0]       al_be;
  logic [XLEN-1:0]  al_wdata;
  logic [XLEN-1:0]  al_ld;
  logic             ex_mem_op;

  assign ex_mem_op = EX_valid & (EX_load | EX_store);

  // Next op record; a bubble still loads the fields but with valid=0.
  always_comb begin
    op_nx            = '0;
    op_nx.valid      = EX_valid;
    op_nx.alu_res    = EX_alu_res;
    op_nx.store_data = EX_store_data;
    op_nx.rd         = EX_rd;
    op_nx.we         = EX_we;
    op_nx.pc         = EX_pc;
    op_nx.jlx        = EX_jlx;
    op_nx.store      = EX_store;
    op_nx.size       = EX_size;
    op_nx.uns        = EX_unsigned;
`ifdef MEM_MISALIGN_EXC_EN
    op_nx.mis        = ex_mem_op & is_misaligned(EX_size, EX_alu_res[1:0]);
`else
    op_nx.mis        = 1'b0;
`endif
  end

  // FSM next state: REQ waits for ack; IDLE/RESP accept a new op.
  always_comb begin
    state_nx = state;
    case (state)
      ST_REQ: begin
        if (dmem_ack) state_nx = ST_RESP;
      end
      default: begin
        if (!ex_mem_op)     state_nx = ST_IDLE;
        else if (op_nx.mis) state_nx = ST_RESP;
        else                state_nx = ST_REQ;
      end
    endcase
  end

  // Stage register: FSM, latched op and formatted load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_r  <= '0;
      ld_r  <= '0;
    end else begin
      state <= state_nx;
      if (!mem_stall) op_r <= op_nx;
      if (state == ST_REQ && dmem_ack) ld_r <= al_ld;
    end
  end

  lsu_align u_align (
    .size        (op_r.size),
    .addr_lo     (op_r.alu_res[1:0]),
    .is_unsigned (op_r.uns),
    .store_data  (op_r.store_data),
    .rdata       (dmem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .ld_data     (al_ld)
  );

  assign mem_stall  = (state == ST_REQ);
  assign dmem_req   = (state == ST_REQ);
  // Memory-side outputs are quiet outside an access.
  assign dmem_we    = dmem_req & op_r.store;
  assign dmem_addr  = dmem_req ? {op_r.alu_res[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = dmem_req ? al_wdata : '0;
  assign dmem_be    = dmem_req ? al_be : '0;

  assign MEM_data_mem = (state == ST_RESP) ? ld_r : op_r.alu_res;
  assign MEM_rd       = op_r.rd;
  assign MEM_pc       = op_r.pc;
  assign MEM_jlx      = op_r.jlx;
  assign MEM_we       = op_r.valid & op_r.we & (state != ST_REQ) & ~op_r.mis;
  assign MEM_misalign = op_r.valid & op_r.mis;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid;
  logic [31:0] EX_alu_res;
  logic [31:0] EX_store_data;
  logic [4:0]  EX_rd;
  logic        EX_we;
  logic [31:0] EX_pc;
  logic        EX_jlx;
  logic        EX_load;
  logic        EX_store;
  logic [1:0]  EX_size;
  logic        EX_unsigned;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MEM_data_mem;
  logic [4:0]  MEM_rd;
  logic        MEM_we;
  logic [31:0] MEM_pc;
  logic        MEM_jlx;
  logic        MEM_misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } dm_t;

  wb_t wb_q[$];
  dm_t dm_q[$];
  int  req_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_alu_res(EX_alu_res), .EX_store_data(EX_store_data),
    .EX_rd(EX_rd), .EX_we(EX_we), .EX_pc(EX_pc), .EX_jlx(EX_jlx),
    .EX_load(EX_load), .EX_store(EX_store), .EX_size(EX_size), .EX_unsigned(EX_unsigned),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_data_mem(MEM_data_mem), .MEM_rd(MEM_rd), .MEM_we(MEM_we), .MEM_pc(MEM_pc),
    .MEM_jlx(MEM_jlx), .MEM_misalign(MEM_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder and request monitor: acks after the expected latency,
  // checking the request against the front of the expected-access queue.
  always @(negedge clk) begin
    dmem_ack = 1'b0;
    if (dmem_req === 1'b1) begin
      if (dm_q.size() > 0 && req_cnt >= dm_q[0].lat) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, dm_q[0].we});
        chk("dmem_addr", dmem_addr, dm_q[0].addr);
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, dm_q[0].be});
        if (dm_q[0].we) chk("dmem_wdata", dmem_wdata, dm_q[0].wdata);
        dmem_rdata = dm_q[0].rdata;
        dmem_ack   = 1'b1;
        void'(dm_q.pop_front());
      end
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
  end

  // Write-back monitor: every MEM_we cycle is one retiring op.
  always @(negedge clk) begin
    if (rst === 1'b0 && MEM_we === 1'b1) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {27'd0, MEM_rd}, 32'hFFFF_FFFF);
      end else begin
        chk("wb_rd", {27'd0, MEM_rd}, {27'd0, wb_q[0].rd});
        chk("wb_data", MEM_data_mem, wb_q[0].data);
        chk("wb_pc", MEM_pc, wb_q[0].pc);
        void'(wb_q.pop_front());
      end
    end
  end

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
    wb_t e;
    e.rd = rd; e.data = data; e.pc = pc;
    wb_q.push_back(e);
  endtask

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
    dm_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.lat = lat; e.rdata = rdata;
    dm_q.push_back(e);
  endtask

  // Drive an op at a falling edge and hold it until the stage will take it.
  task automatic issue(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                       input logic we, input logic [31:0] pc, input logic ld, input logic st,
                       input logic [1:0] sz, input logic uns, input logic jlx);
    int n;
    @(negedge clk);
    EX_valid = 1'b1; EX_alu_res = res; EX_store_data = sd; EX_rd = rd; EX_we = we;
    EX_pc = pc; EX_load = ld; EX_store = st; EX_size = sz; EX_unsigned = uns; EX_jlx = jlx;
    n = 0;
    while (mem_stall !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", n, 0);
  endtask

  task automatic idle();
    @(negedge clk);
    EX_valid = 1'b0;
  endtask

  // Bubble EX, then count stalled cycles (access outstanding).
  task automatic wait_req(input string name, input int exp_cycles);
    int n;
    @(negedge clk);
    EX_valid = 1'b0;
    n = 0;
    while (mem_stall === 1'b1 && n < 100) begin
      if (MEM_we !== 1'b0) chk("we_during_req", {31'd0, MEM_we}, 0);
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; EX_valid = 1'b0; EX_alu_res = '0; EX_store_data = '0; EX_rd = '0;
    EX_we = 1'b0; EX_pc = '0; EX_jlx = 1'b0; EX_load = 1'b0; EX_store = 1'b0;
    EX_size = 2'b00; EX_unsigned = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dmem_req", {31'd0, dmem_req}, 0);
    chk("rst_stall", {31'd0, mem_stall}, 0);
    chk("rst_data", MEM_data_mem, 0);
    chk("rst_rd", {27'd0, MEM_rd}, 0);
    chk("rst_we", {31'd0, MEM_we}, 0);
    chk("rst_pc", MEM_pc, 0);
    chk("rst_jlx", {31'd0, MEM_jlx}, 0);
    chk("rst_misalign", {31'd0, MEM_misalign}, 0);
    rst = 1'b0;

    // ALU op then a jump-and-link, back to back
    push_wb(5'd5, 32'h0000_1234, 32'h40);
    push_wb(5'd1, 32'h0000_0044, 32'h44);
    issue(32'h1234, 0, 5'd5, 1, 32'h40, 0, 0, 2'b10, 0, 0);
    issue(32'h0044, 0, 5'd1, 1, 32'h44, 0, 0, 2'b10, 0, 1);
    idle();
    chk("alu_no_req", {31'd0, dmem_req}, 0);
    chk("jal_jlx", {31'd0, MEM_jlx}, 1);

    // LB signed, ack three cycles late
    push_dm(0, 32'h100, 4'b1000, 0, 3, 32'h80FF_00AA);
    push_wb(5'd6, 32'hFFFF_FF80, 32'h48);
    issue(32'h103, 0, 5'd6, 1, 32'h48, 1, 0, 2'b00, 0, 0);
    wait_req("lb_req_cycles", 4);

    // LBU same address, zero-wait ack
    push_dm(0, 32'h100, 4'b1000, 0, 0, 32'h80FF_00AA);
    push_wb(5'd6, 32'h0000_0080, 32'h4C);
    issue(32'h103, 0, 5'd6, 1, 32'h4C, 1, 0, 2'b00, 1, 0);
    wait_req("lbu_req_cycles", 1);

    // LH upper half signed, LHU lower half
    push_dm(0, 32'h100, 4'b1100, 0, 1, 32'h80FF_00AA);
    push_wb(5'd7, 32'hFFFF_80FF, 32'h50);
    issue(32'h102, 0, 5'd7, 1, 32'h50, 1, 0, 2'b01, 0, 0);
    wait_req("lh_req_cycles", 2);
    push_dm(0, 32'h100, 4'b0011, 0, 0, 32'h80FF_00AA);
    push_wb(5'd8, 32'h0000_00AA, 32'h54);
    issue(32'h100, 0, 5'd8, 1, 32'h54, 1, 0, 2'b01, 1, 0);
    wait_req("lhu_req_cycles", 1);

    // Stores: half, byte, word
    push_dm(1, 32'h200, 4'b1100, 32'h1234_1234, 1, 0);
    issue(32'h202, 32'hABCD_1234, 5'd0, 0, 32'h58, 0, 1, 2'b01, 0, 0);
    wait_req("sh_req_cycles", 2);
    push_dm(1, 32'h200, 4'b0010, 32'h5555_5555, 0, 0);
    issue(32'h201, 32'h0000_0055, 5'd0, 0, 32'h5C, 0, 1, 2'b00, 0, 0);
    wait_req("sb_req_cycles", 1);
    push_dm(1, 32'h300, 4'b1111, 32'hDEAD_BEEF, 2, 0);
    issue(32'h300, 32'hDEAD_BEEF, 5'd0, 0, 32'h60, 0, 1, 2'b10, 0, 0);
    wait_req("sw_req_cycles", 3);

    // Reset in the middle of an access: op is dropped
    issue(32'h400, 0, 5'd9, 1, 32'h64, 1, 0, 2'b10, 0, 0);
    idle();
    chk("midrst_req_before", {31'd0, dmem_req}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'd0, dmem_req}, 0);
    chk("midrst_stall", {31'd0, mem_stall}, 0);
    chk("midrst_we", {31'd0, MEM_we}, 0);
    chk("midrst_rd", {27'd0, MEM_rd}, 0);
    rst = 1'b0;
    idle();

    // Misaligned word load
`ifdef MEM_MISALIGN_EXC_EN
    issue(32'h101, 0, 5'd10, 1, 32'h68, 1, 0, 2'b10, 0, 0);
    idle();
    chk("mis_flag", {31'd0, MEM_misalign}, 1);
    chk("mis_we", {31'd0, MEM_we}, 0);
    chk("mis_req", {31'd0, dmem_req}, 0);
    chk("mis_stall", {31'd0, mem_stall}, 0);
`else
    push_dm(0, 32'h100, 4'b1111, 0, 0, 32'h1122_3344);
    push_wb(5'd10, 32'h1122_3344, 32'h68);
    issue(32'h101, 0, 5'd10, 1, 32'h68, 1, 0, 2'b10, 0, 0);
    wait_req("mis_off_req_cycles", 1);
    chk("mis_off_flag", {31'd0, MEM_misalign}, 0);
`endif

    // Back-to-back loads, both acked in their first REQ cycle
    push_dm(0, 32'h104, 4'b1111, 0, 0, 32'h1234_5678);
    push_wb(5'd11, 32'h1234_5678, 32'h6C);
    push_dm(0, 32'h104, 4'b0010, 0, 0, 32'h0000_AB00);
    push_wb(5'd12, 32'hFFFF_FFAB, 32'h70);
    issue(32'h104, 0, 5'd11, 1, 32'h6C, 1, 0, 2'b10, 0, 0);
    issue(32'h105, 0, 5'd12, 1, 32'h70, 1, 0, 2'b00, 0, 0);
    wait_req("b2b_req_cycles", 1);

    repeat (3) idle();
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("dm_queue_empty", dm_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
